// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator producing pixel coordinates, sync pins, blanking flag,
// pixel tick and end-of-frame strobe from a board clock divided down to the pixel rate.
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_end
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          hs_q, hs_d, vs_q, vs_d, vo_q, vo_d;
    logic          tick, x_end, y_end;

    // Decoded flags only move on pixel edges, so (0,0) stays blanked after reset
    always_comb begin
        tick  = div_q == DIV_LAST;
        x_end = x_q == H_LAST;
        y_end = y_q == V_LAST;
        div_d = tick ? '0 : div_q + DW'(1);
        x_d   = tick ? (x_end ? 10'd0 : x_q + 10'd1) : x_q;
        y_d   = (tick && x_end) ? (y_end ? 10'd0 : y_q + 10'd1) : y_q;
        hs_d  = tick ? !(x_d >= HS_BEG && x_d < HS_END) : hs_q;
        vs_d  = tick ? !(y_d >= VS_BEG && y_d < VS_END) : vs_q;
        vo_d  = tick ? (x_d < H_ACT && y_d < V_ACT) : vo_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vo_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vo_q  <= vo_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign video_on  = vo_q;
    assign p_tick    = tick;
    assign frame_end = tick && x_end && y_end;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks a default-timing instance plus two shrunken-timing instances
// (CLK_DIV 1 and 3) against an arithmetic model of the pixel/line/frame position.
module tb_vga_sync_gen;
    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       pt;
        logic       fe;
    } exp_t;

    typedef struct {
        int cyc;
        int x;
        int y;
        int hs;
        int vs;
        int vo;
        int pt;
    } vec_t;

    localparam int DIVS[3] = '{4, 1, 3};
    localparam int HA[3]   = '{640, 8, 8};
    localparam int HF[3]   = '{16, 2, 2};
    localparam int HSY[3]  = '{96, 3, 3};
    localparam int HB[3]   = '{48, 2, 2};
    localparam int VA[3]   = '{480, 5, 5};
    localparam int VF[3]   = '{10, 1, 1};
    localparam int VSY[3]  = '{2, 2, 2};
    localparam int VB[3]   = '{33, 1, 1};

    logic       clk = 1'b0;
    logic       rst [3];
    logic [9:0] xs [3];
    logic [9:0] ys [3];
    logic       hs [3];
    logic       vs [3];
    logic       vo [3];
    logic       pt [3];
    logic       fe [3];
    int         n  [3];
    int         checks = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_big (
        .clk(clk), .reset(rst[0]), .x(xs[0]), .y(ys[0]), .hsync(hs[0]), .vsync(vs[0]),
        .video_on(vo[0]), .p_tick(pt[0]), .frame_end(fe[0])
    );
    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_d1 (
        .clk(clk), .reset(rst[1]), .x(xs[1]), .y(ys[1]), .hsync(hs[1]), .vsync(vs[1]),
        .video_on(vo[1]), .p_tick(pt[1]), .frame_end(fe[1])
    );
    vga_sync_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_d3 (
        .clk(clk), .reset(rst[2]), .x(xs[2]), .y(ys[2]), .hsync(hs[2]), .vsync(vs[2]),
        .video_on(vo[2]), .p_tick(pt[2]), .frame_end(fe[2])
    );

    // Position follows from how many clock edges have passed since reset release
    function automatic exp_t model(int i, int cyc);
        exp_t e;
        int ht, vt, k, px, py;
        ht = HA[i] + HF[i] + HSY[i] + HB[i];
        vt = VA[i] + VF[i] + VSY[i] + VB[i];
        k  = cyc / DIVS[i];
        px = k % ht;
        py = (k / ht) % vt;
        e.x  = 10'(px);
        e.y  = 10'(py);
        e.pt = (cyc % DIVS[i]) == DIVS[i] - 1;
        e.fe = e.pt && px == ht - 1 && py == vt - 1;
        if (k == 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.vo = 1'b0;
        end else begin
            e.hs = !(px >= HA[i] + HF[i] && px < HA[i] + HF[i] + HSY[i]);
            e.vs = !(py >= VA[i] + VF[i] && py < VA[i] + VF[i] + VSY[i]);
            e.vo = px < HA[i] && py < VA[i];
        end
        return e;
    endfunction

    task automatic check_cycle(int i);
        exp_t e;
        e = model(i, n[i]);
        checks++;
        if ({xs[i], ys[i], hs[i], vs[i], vo[i], pt[i], fe[i]} !== {e.x, e.y, e.hs, e.vs, e.vo, e.pt, e.fe}) begin
            fails++;
            $display("FAIL model dut%0d n=%0d: got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fe=%b, want x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fe=%b",
                     i, n[i], xs[i], ys[i], hs[i], vs[i], vo[i], pt[i], fe[i],
                     e.x, e.y, e.hs, e.vs, e.vo, e.pt, e.fe);
        end
    endtask

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    vec_t tbl[11];
    int   started[3], done[3], per[3], vlow[3], act[3], ptlow[3];
    int   w;

    initial begin
        tbl[0]  = '{0,     0,   0,  1, 1, 0, 0};
        tbl[1]  = '{3,     0,   0,  1, 1, 0, 1};
        tbl[2]  = '{4,     1,   0,  1, 1, 1, 0};
        tbl[3]  = '{7,     1,   0,  1, 1, 1, 1};
        tbl[4]  = '{2560,  640, 0,  1, 1, 0, 0};
        tbl[5]  = '{2624,  656, 0,  0, 1, 0, 0};
        tbl[6]  = '{3004,  751, 0,  0, 1, 0, 0};
        tbl[7]  = '{3008,  752, 0,  1, 1, 0, 0};
        tbl[8]  = '{3200,  0,   1,  1, 1, 1, 0};
        tbl[9]  = '{32020, 5,   10, 1, 1, 1, 0};
        tbl[10] = '{34624, 656, 10, 0, 1, 0, 0};

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            n[i]   = 0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        #1;
        for (int v = 0; v < 11; v++) begin
            while (n[0] < tbl[v].cyc) begin
                @(posedge clk);
                n[0]++;
                @(negedge clk);
                #1;
                check_cycle(0);
            end
            checks++;
            if (xs[0] !== 10'(tbl[v].x) || ys[0] !== 10'(tbl[v].y) || hs[0] !== tbl[v].hs[0] ||
                vs[0] !== tbl[v].vs[0] || vo[0] !== tbl[v].vo[0] || pt[0] !== tbl[v].pt[0]) begin
                fails++;
                $display("FAIL vector cyc=%0d: got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b, want x=%0d y=%0d hs=%0d vs=%0d vo=%0d pt=%0d",
                         tbl[v].cyc, xs[0], ys[0], hs[0], vs[0], vo[0], pt[0],
                         tbl[v].x, tbl[v].y, tbl[v].hs, tbl[v].vs, tbl[v].vo, tbl[v].pt);
            end
        end

        rst[0] = 1'b1;
        #1;
        cmp("async_reset_x", 32'(xs[0]), 0);
        cmp("async_reset_y", 32'(ys[0]), 0);
        cmp("async_reset_hsync", 32'(hs[0]), 1);
        cmp("async_reset_vsync", 32'(vs[0]), 1);
        cmp("async_reset_video_on", 32'(vo[0]), 0);
        cmp("async_reset_p_tick", 32'(pt[0]), 0);

        @(negedge clk);
        rst[1] = 1'b0;
        rst[2] = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            for (int i = 1; i < 3; i++) n[i] = rst[i] ? 0 : n[i] + 1;
            @(negedge clk);
            for (int i = 1; i < 3; i++) begin
                rst[i] = rst[i] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
                if (rst[i]) n[i] = 0;
            end
            #1;
            check_cycle(1);
            check_cycle(2);
        end

        rst[1] = 1'b1;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        rst[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            started[i] = 0; done[i] = 0; per[i] = 0; vlow[i] = 0; act[i] = 0; ptlow[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            for (int i = 1; i < 3; i++) begin
                if (!pt[i]) ptlow[i]++;
                if (started[i] != 0) begin
                    per[i]++;
                    if (!vs[i]) vlow[i]++;
                    if (pt[i] && vo[i]) act[i]++;
                end
                if (fe[i] && done[i] == 0) begin
                    if (started[i] != 0) begin
                        cmp($sformatf("frame_period_dut%0d", i), per[i], 135 * DIVS[i]);
                        cmp($sformatf("vsync_low_clks_dut%0d", i), vlow[i], 30 * DIVS[i]);
                        cmp($sformatf("active_ticks_dut%0d", i), act[i], 40);
                        done[i] = 1;
                    end
                    started[i] = 1;
                    per[i] = 0; vlow[i] = 0; act[i] = 0;
                end
            end
        end
        cmp("frame_measured_dut1", done[1], 1);
        cmp("frame_measured_dut2", done[2], 1);
        cmp("p_tick_low_clks_div1", ptlow[1], 0);

        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (!fe[2] && w < 1000);
        cmp("frame_end_seen", 32'(fe[2]), 1);
        cmp("frame_end_x", 32'(xs[2]), 14);
        cmp("frame_end_y", 32'(ys[2]), 8);
        @(negedge clk);
        #1;
        cmp("frame_end_one_clk", 32'(fe[2]), 0);
        cmp("wrap_x", 32'(xs[2]), 0);
        cmp("wrap_y", 32'(ys[2]), 0);
        cmp("wrap_video_on", 32'(vo[2]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
